// File: rtl/arb_pkg.sv
// Shared types and sizes for the four-source round-robin arbiter.
package arb_pkg;
   typedef logic [1:0] src_idx_t;
   localparam int N_SRC  = 4;
   localparam int DATA_W = 4;
endpackage

// File: rtl/rr_arb_4_1_if.sv
// Handshake bundle between four producers, the arbiter and one consumer.
interface rr_arb_4_1_if;
   import arb_pkg::*;

   logic [N_SRC-1:0]  in_valid;
   logic [N_SRC-1:0]  in_ready;
   logic [DATA_W-1:0] d0;
   logic [DATA_W-1:0] d1;
   logic [DATA_W-1:0] d2;
   logic [DATA_W-1:0] d3;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   src_idx_t          out_sel;

   // master = producers and consumer, slave = arbiter
   modport master (
      output in_valid, d0, d1, d2, d3, out_ready,
      input  in_ready, out_valid, out_data, out_sel
   );

   modport slave (
      input  in_valid, d0, d1, d2, d3, out_ready,
      output in_ready, out_valid, out_data, out_sel
   );
endinterface

// File: rtl/rr_arb_4_1_pick.sv
// Combinational round-robin winner search starting at the priority pointer.
module rr_pick_4
   import arb_pkg::*;
(
   input  logic [N_SRC-1:0] req,
   input  src_idx_t         ptr,
   output logic             any,
   output src_idx_t         idx
);

   src_idx_t cand;

   // Scan from the farthest offset back to ptr so the nearest requester wins.
   always_comb begin
      any  = |req;
      idx  = ptr;
      cand = ptr;
      for (int k = N_SRC - 1; k >= 0; k--) begin
         cand = ptr + src_idx_t'(k);
         if (req[cand]) begin
            idx = cand;
         end
      end
   end

endmodule

// File: rtl/rr_arb_4_1.sv
// Four-input round-robin arbiter feeding a one-entry output register.
module rr_arb_4_1
   import arb_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   rr_arb_4_1_if.slave      bus,
   output logic [CNT_W-1:0] grant_cnt
);

   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q,  out_data_d;
   src_idx_t          out_sel_q,   out_sel_d;
   src_idx_t          ptr_q,       ptr_d;
   logic [CNT_W-1:0]  cnt_q,       cnt_d;

   logic              load;
   logic              pick_any;
   src_idx_t          pick_idx;
   logic [DATA_W-1:0] pick_data;

   rr_pick_4 u_pick (
      .req (bus.in_valid),
      .ptr (ptr_q),
      .any (pick_any),
      .idx (pick_idx)
   );

   assign load = !out_valid_q || bus.out_ready;

   always_comb begin
      pick_data = bus.d0;
      case (pick_idx)
         2'd0:    pick_data = bus.d0;
         2'd1:    pick_data = bus.d1;
         2'd2:    pick_data = bus.d2;
         default: pick_data = bus.d3;
      endcase
   end

   always_comb begin
      bus.in_ready = '0;
      if (load && pick_any) begin
         bus.in_ready[pick_idx] = 1'b1;
      end
   end

   // An empty or draining register either takes the winner or goes empty.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      if (load) begin
         if (pick_any) begin
            out_valid_d = 1'b1;
            out_data_d  = pick_data;
            out_sel_d   = pick_idx;
            ptr_d       = pick_idx + 2'd1;
            cnt_d       = cnt_q + CNT_W'(1);
         end else begin
            out_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
         ptr_q       <= '0;
         cnt_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_sel   = out_sel_q;
   assign grant_cnt     = cnt_q;

endmodule

// File: tb/tb_rr_arb_4_1.sv
// Scoreboard bench: directed stimulus queues expected words, a monitor checks them on drain.
module tb_rr_arb_4_1;
   import arb_pkg::*;

   logic       clk;
   logic       rst;
   logic [7:0] grant_cnt;
   logic [1:0] grant_cnt2;
   int         checks;
   int         errors;
   logic [5:0] sb[$];

   rr_arb_4_1_if bus ();
   rr_arb_4_1_if bus2 ();

   rr_arb_4_1 #(.CNT_W(8)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus.slave),
      .grant_cnt (grant_cnt)
   );

   // Narrow-counter copy sees identical traffic to exercise counter wrap.
   assign bus2.in_valid  = bus.in_valid;
   assign bus2.d0        = bus.d0;
   assign bus2.d1        = bus.d1;
   assign bus2.d2        = bus.d2;
   assign bus2.d3        = bus.d3;
   assign bus2.out_ready = bus.out_ready;

   rr_arb_4_1 #(.CNT_W(2)) u_dut2 (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus2.slave),
      .grant_cnt (grant_cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic [3:0] v, input logic rdy, input logic [3:0] d2v,
                                input logic [3:0] exp_ready, input logic push,
                                input logic [1:0] esel, input logic [3:0] edata);
      @(posedge clk);
      #2;
      rst           = r;
      bus.in_valid  = v;
      bus.out_ready = rdy;
      bus.d2        = d2v;
      #1;
      checkOutput("in_ready", 32'(bus.in_ready), 32'(exp_ready));
      if (push) sb.push_back({esel, edata});
   endtask

   // Monitor: a word leaving the register must match the oldest expected word.
   initial begin
      logic [5:0] exp_word;
      forever begin
         @(negedge clk);
         if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_word: got %0h expected none at %0t",
                        {bus.out_sel, bus.out_data}, $time);
            end else begin
               exp_word = sb.pop_front();
               checkOutput("out_word", 32'({bus.out_sel, bus.out_data}), 32'(exp_word));
            end
         end
      end
   end

   initial begin
      logic [3:0] oh_tbl[4];
      logic [3:0] dat_tbl[4];
      logic [1:0] cnt2_tbl[8];
      oh_tbl   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
      dat_tbl  = '{4'hA, 4'hB, 4'hC, 4'hD};
      cnt2_tbl = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus.in_valid  = 4'b0000;
      bus.out_ready = 1'b0;
      bus.d0 = 4'hA;
      bus.d1 = 4'hB;
      bus.d2 = 4'hC;
      bus.d3 = 4'hD;

      repeat (2) applyStimulus(1'b1, 4'b0000, 1'b0, 4'hC, 4'b0000, 1'b0, 2'd0, 4'h0);
      repeat (3) applyStimulus(1'b0, 4'b0000, 1'b1, 4'hC, 4'b0000, 1'b0, 2'd0, 4'h0);
      checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("reset_out_data",  32'(bus.out_data),  32'd0);
      checkOutput("reset_out_sel",   32'(bus.out_sel),   32'd0);
      checkOutput("reset_grant_cnt", 32'(grant_cnt),     32'd0);

      for (int k = 0; k < 8; k++) begin
         applyStimulus(1'b0, 4'b1111, 1'b1, 4'hC, oh_tbl[k % 4], 1'b1, 2'(k % 4), dat_tbl[k % 4]);
         checkOutput("grant_cnt", 32'(grant_cnt), 32'(k));
         checkOutput("grant_cnt_w2", 32'(grant_cnt2), 32'(cnt2_tbl[k]));
      end

      applyStimulus(1'b0, 4'b0100, 1'b1, 4'h5, 4'b0100, 1'b1, 2'd2, 4'h5);
      checkOutput("grant_cnt_after8", 32'(grant_cnt), 32'd8);
      applyStimulus(1'b0, 4'b0110, 1'b1, 4'h5, 4'b0010, 1'b1, 2'd1, 4'hB);
      checkOutput("grant_cnt_wrap_ptr", 32'(grant_cnt), 32'd9);

      repeat (4) begin
         applyStimulus(1'b0, 4'b1111, 1'b0, 4'h5, 4'b0000, 1'b0, 2'd0, 4'h0);
         checkOutput("stall_out_valid", 32'(bus.out_valid), 32'd1);
         checkOutput("stall_out_data",  32'(bus.out_data),  32'hB);
         checkOutput("stall_out_sel",   32'(bus.out_sel),   32'd1);
         checkOutput("stall_grant_cnt", 32'(grant_cnt),     32'd10);
      end
      applyStimulus(1'b0, 4'b1111, 1'b1, 4'h5, 4'b0100, 1'b1, 2'd2, 4'h5);
      checkOutput("resume_grant_cnt", 32'(grant_cnt), 32'd10);

      applyStimulus(1'b0, 4'b0010, 1'b1, 4'h5, 4'b0010, 1'b1, 2'd1, 4'hB);
      checkOutput("pre_rst_grant_cnt", 32'(grant_cnt), 32'd11);
      applyStimulus(1'b1, 4'b1111, 1'b0, 4'h5, 4'b0000, 1'b0, 2'd0, 4'h0);
      checkOutput("rst_cycle_out_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("rst_cycle_grant_cnt", 32'(grant_cnt), 32'd12);
      if (sb.size() > 0) void'(sb.pop_front());

      applyStimulus(1'b0, 4'b1111, 1'b1, 4'h5, 4'b0001, 1'b1, 2'd0, 4'hA);
      checkOutput("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("post_rst_grant_cnt", 32'(grant_cnt), 32'd0);
      checkOutput("post_rst_grant_cnt_w2", 32'(grant_cnt2), 32'd0);
      applyStimulus(1'b0, 4'b0000, 1'b1, 4'h5, 4'b0000, 1'b0, 2'd0, 4'h0);
      checkOutput("final_grant_cnt", 32'(grant_cnt), 32'd1);
      checkOutput("final_out_valid", 32'(bus.out_valid), 32'd1);
      applyStimulus(1'b0, 4'b0000, 1'b1, 4'h5, 4'b0000, 1'b0, 2'd0, 4'h0);
      checkOutput("drained_out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rr_arb_4_1.md
# rr_arb_4_1

- Four-input round-robin arbiter with valid/ready handshakes on every port.
- Each cycle it picks one requesting 4-bit source, passes that source's data through a case-based 4:1 select, and holds the result in a one-entry output register.
- Sits directly upstream of the downstream consumer, so four producers can share one 4-bit channel fairly.
- `out_sel` reports which source each held word came from.

## Interface
Parameters:
- `CNT_W`, default 8: width of the wrapping accepted-grant counter.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  4  bit i = source i has a word.
- `in_ready`  out  4  bit i = source i's word is taken this cycle; one-hot or zero.
- `d0`, `d1`, `d2`, `d3`  in  4 each  source data.
- `out_valid`  out  1  output register holds a word.
- `out_ready`  in  1  consumer takes the word.
- `out_data`  out  4  held word.
- `out_sel`  out  2  index of the source that supplied `out_data`.
- `grant_cnt`  out  `CNT_W`  number of accepted transfers, modulo 2^`CNT_W`.

## Operation
State:
- Output register: `out_valid`, `out_data`, `out_sel`.
- Priority pointer `ptr[1:0]`.
- `grant_cnt`.

Load and grant:
- `load` = !`out_valid` | `out_ready`. The register is empty or drains this cycle.
- Winner search: first i with `in_valid[i]`=1, scanning `ptr`, `ptr`+1, `ptr`+2, `ptr`+3 (mod 4).
- `in_ready[i]` = `load` & (a request exists) & (i == winner). All other bits are 0.
- `in_ready` may depend combinationally on `in_valid` and `out_ready`. `out_valid` never depends on `out_ready` combinationally.

On accept (`load` & any `in_valid`):
- `out_data` ← d[winner], selected through a case statement on the winner index.
- `out_sel` ← winner; `out_valid` ← 1.
- `ptr` ← winner+1, wrapping 3→0.
- `grant_cnt` ← `grant_cnt`+1, wrapping at 2^`CNT_W`.

Other cases:
- `load` with no request: `out_valid` ← 0. `out_data` and `out_sel` hold their last value. `ptr` unchanged.
- No `load` (full and stalled): all state holds, `in_ready` = 0.
- A source that deasserts `in_valid` before it is granted loses nothing: no state records it, and `ptr` does not move for it.
- Simultaneous drain and accept in one cycle: the old word leaves and the new word is loaded. No bubble.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_sel`=0, `ptr`=0, `grant_cnt`=0, so `in_ready`=0 only once output is full (after reset, register empty → grants allowed the first cycle).
- Latency: a word accepted in cycle N appears on `out_*` with `out_valid`=1 in cycle N+1.
- Throughput: one word per cycle while `out_ready`=1 and any request is present.
- Fairness: with all four sources continuously valid, grants go 0,1,2,3,0,… One source never wins twice while another is continuously waiting.
- `rst` asserted mid-operation discards the held word and the pointer on the next edge; `in_ready` is not forced to 0 during the reset cycle, but no transfer is counted.

## Structure
- Shared package `arb_pkg`:
  - `typedef logic [1:0] src_idx_t`
  - `localparam int N_SRC = 4`
  - `localparam int DATA_W = 4`
- One natural sub-module, `rr_pick_4`. It is combinational: inputs `req[3:0]` and `ptr`; outputs `any` and `idx`.
- Top level holds the register, pointer, counter and the case-based data select.

## Test plan
- Reset, then `in_valid`=4'b0000 for 3 cycles → `out_valid`=0, `out_data`=0, `out_sel`=0, `grant_cnt`=0.
- `in_valid`=4'b1111, `out_ready`=1, d0..d3 = 4'hA, 4'hB, 4'hC, 4'hD for 8 cycles.
  - `out_sel` sequence 0,1,2,3,0,1,2,3, starting one cycle after the first grant.
  - `out_data` sequence A,B,C,D,…; `grant_cnt`=8.
- Only `in_valid[2]`=1 (d2=4'h5), then add `in_valid[1]` → the next grant goes to source 1, because `ptr`=3 wraps to 0 and then 1. `out_data`=4'h5 first.
- `out_valid`=1 with `out_ready`=0 for 4 cycles, all sources valid → `in_ready`=0. `out_data` and `out_sel` are stable, and `grant_cnt` does not change.
- `CNT_W`=2, 5 accepts → `grant_cnt`=1.
- Assert `rst` for one cycle while `out_valid`=1 and `ptr`=2 → next cycle `out_valid`=0 and `grant_cnt`=0. With all sources valid, the first grant goes to source 0.
